// File: rtl/spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// spi_master_ctrl
//
// Upstream SPI master for SPI_Slave. Turns a parallel request (2-bit op plus
// 8-bit payload) into one SS_n/MOSI frame at one bit per clk. On a read-data
// frame it sends the command and DUMMY_BITS zero bits. It then waits
// RD_LATENCY cycles for the RAM behind the slave, and shifts 8 MISO bits in,
// MSB first.
//
// Frame layout (SS_n low throughout):
//   START(1) CMD(3) PAYLOAD(8)                              -> END(IDLE_GAP)
//   START(1) CMD(3) DUMMY(DUMMY_BITS) WAIT(RD_LATENCY) CAPTURE(8) -> END
//
// Parameters:
//   IDLE_GAP    min cycles SS_n is held high after a frame (>= 1)
//   RD_LATENCY  cycles between the last dummy bit and the first MISO sample
//   DUMMY_BITS  zero bits sent after the read-data command (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   req_valid  request present
//   req_ready  high only in IDLE; request taken on req_valid && req_ready
//   req_op     00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   req_data   address/data payload (ignored for op 11)
//   rsp_valid  one-cycle pulse when rsp_data is updated
//   rsp_data   byte captured from MISO, held until the next read completes
//   busy       high while the FSM is not in IDLE
//   SS_n       slave select, active low
//   MOSI       serial data to the slave
//   MISO       serial data from the slave
//   err        (SPI_MASTER_SEQ_CHECK_EN only) one-cycle pulse when a
//              read-data request arrives with no read address loaded
//
// Optional feature: define SPI_MASTER_SEQ_CHECK_EN to enable the read
// sequence check and the err port. Default build has neither.
// ----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int unsigned IDLE_GAP   = 1,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned DUMMY_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
`ifdef SPI_MASTER_SEQ_CHECK_EN
    input  logic       MISO,
    output logic       err
`else
    input  logic       MISO
`endif
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CMD,
        ST_PAYLOAD,
        ST_DUMMY,
        ST_WAIT,
        ST_CAPTURE,
        ST_END,
        ST_ERR      // reachable only with the sequence check enabled
    } state_e;

    localparam logic [1:0]  OP_RD_ADDR = 2'b10;
    localparam logic [1:0]  OP_RD_DATA = 2'b11;

    // Last count value of each multi-cycle state (counter restarts at 0 on entry).
    localparam logic [15:0] DUMMY_LAST = 16'(DUMMY_BITS - 1);
    localparam logic [15:0] WAIT_LAST  = 16'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
    localparam logic [15:0] GAP_LAST   = 16'(IDLE_GAP - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  payload_q, payload_d;
    logic [7:0]  rx_q, rx_d;

    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        busy_q, busy_d;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic        addr_loaded_q, addr_loaded_d;
    logic        err_q, err_d;
`endif

    logic        accept;
    assign accept = req_valid && req_ready_q;

    // ------------------------------------------------------------------------
    // State register (also holds the registered outputs)
    // ------------------------------------------------------------------------
    // NOTE: every flop is reset, datapath included, so an aborted frame leaves
    // no partial op, payload or rx byte behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            payload_q     <= '0;
            rx_q          <= '0;
            ss_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            busy_q        <= 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
            addr_loaded_q <= 1'b0;
            err_q         <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            payload_q     <= payload_d;
            rx_q          <= rx_d;
            ss_n_q        <= ss_n_d;
            mosi_q        <= mosi_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            busy_q        <= busy_d;
`ifdef SPI_MASTER_SEQ_CHECK_EN
            addr_loaded_q <= addr_loaded_d;
            err_q         <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        op_d      = op_q;
        payload_d = payload_q;
        rx_d      = rx_q;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        addr_loaded_d = addr_loaded_q;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    op_d      = req_op;
                    payload_d = req_data;
                    rx_d      = '0;
                    state_d   = ST_START;
`ifdef SPI_MASTER_SEQ_CHECK_EN
                    // Reading data before any read address: consume, flag, no frame.
                    if (req_op == OP_RD_DATA && !addr_loaded_q) begin
                        state_d = ST_ERR;
                    end
`endif
                end
            end
            ST_START: begin
                state_d = ST_CMD;
                cnt_d   = '0;
            end
            ST_CMD: begin
                if (cnt_q == 16'd2) begin
                    state_d = (op_q == OP_RD_DATA) ? ST_DUMMY : ST_PAYLOAD;
                    cnt_d   = '0;
                end
            end
            ST_PAYLOAD: begin
                if (cnt_q == 16'd7) begin
                    state_d = ST_END;
                    cnt_d   = '0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
                    if (op_q == OP_RD_ADDR) begin
                        addr_loaded_d = 1'b1;
                    end
`endif
                end
            end
            ST_DUMMY: begin
                if (cnt_q == DUMMY_LAST) begin
                    state_d = (RD_LATENCY == 0) ? ST_CAPTURE : ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end
            end
            ST_CAPTURE: begin
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == 16'd7) begin
                    state_d = ST_END;
                    cnt_d   = '0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
                    addr_loaded_d = 1'b0;
`endif
                end
            end
            ST_END: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: decoded from the next state so the registered outputs
    // line up cycle-for-cycle with state_q.
    // ------------------------------------------------------------------------
    always_comb begin
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef SPI_MASTER_SEQ_CHECK_EN
        err_d       = (state_d == ST_ERR);
`endif

        case (state_d)
            ST_START, ST_DUMMY, ST_WAIT, ST_CAPTURE: begin
                ss_n_d = 1'b0;
            end
            ST_CMD: begin
                ss_n_d = 1'b0;
                // Command bits are op[1], op[1], op[0].
                mosi_d = (cnt_d == 16'd2) ? op_d[0] : op_d[1];
            end
            ST_PAYLOAD: begin
                ss_n_d = 1'b0;
                // MSB first: count 0..7 selects bit 7..0.
                mosi_d = payload_d[~cnt_d[2:0]];
            end
            default: ;
        endcase

        // The edge that takes the 8th MISO sample also publishes the byte.
        if (state_q == ST_CAPTURE && state_d == ST_END) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_master_ctrl
//
// Directed bench for spi_master_ctrl. A small behavioural SPI_Slave + RAM model
// watches SS_n/MOSI, stores written bytes and drives MISO on read-data frames.
// A frame monitor records SS_n-low lengths, MOSI bit patterns, SS_n-high gaps
// and rsp_valid pulses. Each test task checks against hand-computed values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_ctrl;

    localparam int IDLE_GAP   = 1;
    localparam int RD_LATENCY = 1;
    localparam int DUMMY_BITS = 8;
    localparam int CAP0       = 4 + DUMMY_BITS + RD_LATENCY;  // first capture cycle in frame
    localparam int RD_FRAME   = CAP0 + 8;                     // 21 with defaults

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       ss_n;
    logic       mosi;
    logic       miso = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic       err;
`endif

    int checks = 0;
    int passes = 0;

    spi_master_ctrl #(
        .IDLE_GAP  (IDLE_GAP),
        .RD_LATENCY(RD_LATENCY),
        .DUMMY_BITS(DUMMY_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .SS_n     (ss_n),
        .MOSI     (mosi),
`ifdef SPI_MASTER_SEQ_CHECK_EN
        .MISO     (miso),
        .err      (err)
`else
        .MISO     (miso)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- frame monitor + slave/RAM model ----------------
    int          frame_lens[$];
    logic [31:0] frame_vecs[$];
    int          gaps[$];
    int          rsp_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  mem [256];
    logic [7:0]  wr_addr = 8'h00;
    logic [7:0]  rd_addr = 8'h00;

    initial begin : monitor
        int          ss_cur;
        int          hi_cnt;
        logic        ss_prev;
        logic [31:0] vec;
        logic [2:0]  cmd;
        logic [7:0]  pay;
        logic [7:0]  cur;
        logic [2:0]  bidx;
        ss_cur = 0; hi_cnt = 0; ss_prev = 1'b1; vec = '0; cmd = '0; pay = '0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rsp_cnt++;
`ifdef SPI_MASTER_SEQ_CHECK_EN
            if (err === 1'b1) err_cnt++;
`endif
            if (ss_n === 1'b0) begin
                if (ss_prev) begin
                    gaps.push_back(hi_cnt);
                    ss_cur = 0;
                    vec    = '0;
                end
                vec = {vec[30:0], mosi};
                if (ss_cur >= 1 && ss_cur <= 3)  cmd = {cmd[1:0], mosi};
                if (ss_cur >= 4 && ss_cur <= 11) pay = {pay[6:0], mosi};
                if (ss_cur == 11) begin
                    case (cmd)
                        3'b000:  wr_addr = pay;
                        3'b001:  mem[wr_addr] = pay;
                        3'b110:  rd_addr = pay;
                        default: ;
                    endcase
                end
                if (cmd == 3'b111 && ss_cur >= CAP0 && ss_cur < CAP0 + 8) begin
                    cur  = mem[rd_addr];
                    bidx = 3'(ss_cur - CAP0);
                    miso = cur[3'd7 - bidx];
                end else begin
                    miso = 1'b0;
                end
                ss_cur++;
                hi_cnt  = 0;
                ss_prev = 1'b0;
            end else begin
                if (!ss_prev) begin
                    frame_lens.push_back(ss_cur);
                    frame_vecs.push_back(vec);
                end
                hi_cnt++;
                miso    = 1'b0;
                ss_prev = 1'b1;
            end
        end
    end

    function automatic int get_len(input int idx);
        return (idx < frame_lens.size()) ? frame_lens[idx] : -1;
    endfunction

    function automatic logic [31:0] get_vec(input int idx);
        return (idx < frame_vecs.size()) ? frame_vecs[idx] : 32'hFFFF_FFFF;
    endfunction

    function automatic int get_gap(input int idx);
        return (idx < gaps.size()) ? gaps[idx] : -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_req(input logic [1:0] op, input logic [7:0] data);
        bit ok;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_data = data;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (req_ready === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) $display("FAIL accept_timeout: req_ready never rose for op %b", op);
        else passes++;
        if (ok) begin
            @(posedge clk); #1;
        end
        // Scramble inputs after acceptance: the DUT must use its latched copy.
        req_valid = 1'b0; req_op = ~op; req_data = ~data;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
        end
        checks++;
        if (!done) $display("FAIL idle_timeout: busy still %b", busy);
        else passes++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ss_n !== 1'b1) $display("FAIL reset_ss_n: got %b want 1", ss_n); else passes++;
        checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi); else passes++;
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passes++;
        checks++; if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %h want 00", rsp_data); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", req_ready); else passes++;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", req_ready); else passes++;
    endtask

    task automatic test_write_addr();
        int f0, r0;
        f0 = frame_lens.size(); r0 = rsp_cnt;
        do_req(2'b00, 8'hA5);
        checks++; if (busy !== 1'b1) $display("FAIL wa_busy: got %b want 1", busy); else passes++;
        checks++; if (req_ready !== 1'b0) $display("FAIL wa_ready_drop: got %b want 0", req_ready); else passes++;
        checks++; if (ss_n !== 1'b0) $display("FAIL wa_start_ss_n: got %b want 0", ss_n); else passes++;
        wait_idle();
        checks++; if (get_len(f0) !== 12) $display("FAIL wa_len: got %0d want 12", get_len(f0)); else passes++;
        checks++; if (get_vec(f0) !== 32'h0A5) $display("FAIL wa_bits: got %h want 0a5", get_vec(f0)); else passes++;
        checks++; if (rsp_cnt !== r0) $display("FAIL wa_no_rsp: got %0d pulses want 0", rsp_cnt - r0); else passes++;
    endtask

    task automatic test_write_data();
        int f0;
        f0 = frame_lens.size();
        do_req(2'b01, 8'h3C);
        wait_idle();
        checks++; if (get_len(f0) !== 12) $display("FAIL wd_len: got %0d want 12", get_len(f0)); else passes++;
        checks++; if (get_vec(f0) !== 32'h13C) $display("FAIL wd_bits: got %h want 13c", get_vec(f0)); else passes++;
        checks++; if (ss_n !== 1'b1) $display("FAIL wd_gap_ss_n: got %b want 1", ss_n); else passes++;
    endtask

    task automatic test_loopback();
        int f0, r0;
        f0 = frame_lens.size();
        do_req(2'b00, 8'h12); wait_idle();
        do_req(2'b01, 8'hC7); wait_idle();
        do_req(2'b10, 8'h12); wait_idle();
        r0 = rsp_cnt;
        do_req(2'b11, 8'h5A); wait_idle();
        checks++; if (get_vec(f0 + 1) !== 32'h1C7) $display("FAIL lb_wd_bits: got %h want 1c7", get_vec(f0 + 1)); else passes++;
        checks++; if (get_vec(f0 + 2) !== 32'h612) $display("FAIL lb_ra_bits: got %h want 612", get_vec(f0 + 2)); else passes++;
        checks++; if (get_len(f0 + 3) !== RD_FRAME) $display("FAIL lb_rd_len: got %0d want %0d", get_len(f0 + 3), RD_FRAME); else passes++;
        checks++; if (get_vec(f0 + 3) !== 32'h0E0000) $display("FAIL lb_rd_bits: got %h want 0e0000", get_vec(f0 + 3)); else passes++;
        checks++; if (rsp_cnt - r0 !== 1) $display("FAIL lb_rsp_pulses: got %0d want 1", rsp_cnt - r0); else passes++;
        checks++; if (rsp_data !== 8'hC7) $display("FAIL lb_rsp_data: got %h want c7", rsp_data); else passes++;
        repeat (5) @(negedge clk);
        checks++; if (rsp_data !== 8'hC7) $display("FAIL lb_rsp_hold: got %h want c7", rsp_data); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops  [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
        logic [7:0]  dat  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [31:0] exp_v[4] = '{32'h011, 32'h122, 32'h033, 32'h144};
        int f0, g0;
        bit ok;
        f0 = frame_lens.size(); g0 = gaps.size();
        @(negedge clk);
        req_valid = 1'b1; req_op = ops[0]; req_data = dat[0];
        for (int i = 0; i < 4; i++) begin
            ok = 1'b0;
            for (int n = 0; n < 100 && !ok; n++) begin
                if (req_ready === 1'b1) ok = 1'b1;
                else @(negedge clk);
            end
            checks++;
            if (!ok) $display("FAIL b2b_accept_%0d: req_ready stuck at %b", i, req_ready);
            else passes++;
            @(posedge clk); #1;
            if (i < 3) begin
                req_op = ops[i + 1]; req_data = dat[i + 1];
            end else begin
                req_valid = 1'b0;
            end
        end
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (get_vec(f0 + i) !== exp_v[i])
                $display("FAIL b2b_bits_%0d: got %h want %h", i, get_vec(f0 + i), exp_v[i]);
            else passes++;
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (get_gap(g0 + i) !== IDLE_GAP + 1)
                $display("FAIL b2b_gap_%0d: got %0d want %0d", i, get_gap(g0 + i), IDLE_GAP + 1);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0;
        do_req(2'b10, 8'h12); wait_idle();
        r0 = rsp_cnt;
        do_req(2'b11, 8'h00);
        // After the accept edge we are in frame cycle 0; land in capture bit 4.
        repeat (CAP0 + 5) @(negedge clk);
        checks++; if (ss_n !== 1'b0) $display("FAIL rm_in_frame: got %b want 0", ss_n); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (ss_n !== 1'b1) $display("FAIL rm_ss_n: got %b want 1", ss_n); else passes++;
        checks++; if (mosi !== 1'b0) $display("FAIL rm_mosi: got %b want 0", mosi); else passes++;
        checks++; if (rsp_data !== 8'h00) $display("FAIL rm_rsp_data: got %h want 00", rsp_data); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else passes++;
        checks++; if (req_ready !== 1'b0) $display("FAIL rm_ready: got %b want 0", req_ready); else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", req_ready); else passes++;
        repeat (30) @(negedge clk);
        checks++; if (rsp_cnt !== r0) $display("FAIL rm_no_rsp: got %0d pulses want 0", rsp_cnt - r0); else passes++;
        checks++; if (rsp_data !== 8'h00) $display("FAIL rm_rsp_data_hold: got %h want 00", rsp_data); else passes++;
        checks++; if (ss_n !== 1'b1) $display("FAIL rm_ss_n_idle: got %b want 1", ss_n); else passes++;
    endtask

`ifdef SPI_MASTER_SEQ_CHECK_EN
    task automatic test_seq_check();
        int f0, e0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        f0 = frame_lens.size(); e0 = err_cnt;
        do_req(2'b11, 8'h00);
        checks++; if (err !== 1'b1) $display("FAIL sc_err_pulse: got %b want 1", err); else passes++;
        checks++; if (ss_n !== 1'b1) $display("FAIL sc_ss_n: got %b want 1", ss_n); else passes++;
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) $display("FAIL sc_err_clear: got %b want 0", err); else passes++;
        wait_idle();
        checks++; if (frame_lens.size() !== f0) $display("FAIL sc_no_frame: got %0d frames want 0", frame_lens.size() - f0); else passes++;
        checks++; if (err_cnt - e0 !== 1) $display("FAIL sc_err_len: got %0d cycles want 1", err_cnt - e0); else passes++;
        do_req(2'b10, 8'h12); wait_idle();
        e0 = err_cnt;
        do_req(2'b11, 8'h00); wait_idle();
        checks++; if (err_cnt !== e0) $display("FAIL sc_err_ok: got %0d cycles want 0", err_cnt - e0); else passes++;
        checks++; if (get_len(f0 + 1) !== RD_FRAME) $display("FAIL sc_rd_len: got %0d want %0d", get_len(f0 + 1), RD_FRAME); else passes++;
        checks++; if (rsp_data !== 8'hC7) $display("FAIL sc_rsp_data: got %h want c7", rsp_data); else passes++;
    endtask
`endif

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_write_addr();
        test_write_data();
        test_loopback();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SPI_MASTER_SEQ_CHECK_EN
        test_seq_check();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
